// File: rtl/mio_arb_pkg.sv
// Shared definitions for the two-master memory/IO arbiter: FSM states,
// one-hot grant encodings, the read value returned on a watchdog abort,
// and the fixed/round-robin winner selection helper.
package mio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    localparam int ABORT_RDATA = 0;

    // Resolves a request pair to a one-hot winner; prefer_m1 only matters
    // when both masters request in the same cycle.
    function automatic logic [1:0] pick_winner(input logic req0,
                                               input logic req1,
                                               input logic prefer_m1);
        logic [1:0] win;
        win = GRANT_NONE;
        if (req0 && req1) begin
            win = prefer_m1 ? GRANT_M1 : GRANT_M0;
        end else if (req0) begin
            win = GRANT_M0;
        end else if (req1) begin
            win = GRANT_M1;
        end
        return win;
    endfunction

endpackage

// File: rtl/mio_arb_watchdog.sv
// Busy-cycle watchdog for the arbiter. Counts cycles while enabled and
// flags expiry during the TIMEOUT-th enabled cycle. TIMEOUT = 0 disables it.
module mio_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Cycle counter: restarts whenever the transfer is not in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (TIMEOUT != 0) && enable && (count == LAST);

endmodule

// File: rtl/mio_arbiter.sv
// Two-master arbiter in front of a single memory/IO port.
// Master 0 is the CPU, master 1 the secondary (DMA/display) master.
// Optional feature: define MIO_ARB_ROUND_ROBIN_EN to alternate the winner on
// simultaneous requests; otherwise master 0 always wins a tie.
module mio_arbiter
    import mio_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ready,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ready,
    output logic          m1_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [1:0]    grant
);

    arb_state_t    state;
    arb_state_t    state_next;
    logic [1:0]    winner;
    logic [1:0]    grant_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] m0_rdata_q;
    logic [DW-1:0] m1_rdata_q;
    logic          err_q;
    logic          wd_expire;

`ifdef MIO_ARB_ROUND_ROBIN_EN
    logic last_m1;

    // Remembers who won the previous arbitration so a tie goes to the other master.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_m1 <= 1'b1;
        end else if (state == IDLE && state_next == BUSY) begin
            last_m1 <= winner[1];
        end
    end

    assign winner = pick_winner(m0_req, m1_req, !last_m1);
`else
    assign winner = pick_winner(m0_req, m1_req, 1'b0);
`endif

    mio_arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .clear (state != BUSY),
        .enable(state == BUSY),
        .expire(wd_expire)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; an ack in the expiry cycle still counts as completion.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (m0_req || m1_req) state_next = BUSY;
            BUSY:    if (mem_ack || wd_expire) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Transfer datapath: latch the winner's command, capture read data or abort value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_q    <= GRANT_NONE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (state_next == BUSY) begin
                        grant_q <= winner;
                        we_q    <= (winner == GRANT_M1) ? m1_we    : m0_we;
                        addr_q  <= (winner == GRANT_M1) ? m1_addr  : m0_addr;
                        wdata_q <= (winner == GRANT_M1) ? m1_wdata : m0_wdata;
                        err_q   <= 1'b0;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        if (grant_q[0]) m0_rdata_q <= mem_rdata;
                        if (grant_q[1]) m1_rdata_q <= mem_rdata;
                        err_q <= 1'b0;
                    end else if (wd_expire) begin
                        if (grant_q[0]) m0_rdata_q <= DW'(ABORT_RDATA);
                        if (grant_q[1]) m1_rdata_q <= DW'(ABORT_RDATA);
                        err_q <= 1'b1;
                    end
                end
                DONE: begin
                    grant_q <= GRANT_NONE;
                end
                default: begin
                    grant_q <= GRANT_NONE;
                end
            endcase
        end
    end

    assign mem_req   = (state == BUSY);
    assign mem_we    = we_q && mem_req;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign grant     = grant_q;

    assign m0_ready  = (state == DONE) && grant_q[0];
    assign m1_ready  = (state == DONE) && grant_q[1];
    assign m0_err    = m0_ready && err_q;
    assign m1_err    = m1_ready && err_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_mio_arbiter.sv
// Self-checking bench for mio_arbiter. A transaction-level model decides the
// winner, completion cycle, error flag and returned data of each transfer.
module tb_mio_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 8;
    localparam int NO_ACK  = 1000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic [DW-1:0] m0_rdata;
    logic          m0_ready, m0_err;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic [DW-1:0] m1_rdata;
    logic          m1_ready, m1_err;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic [1:0]    grant;

    int checks = 0;
    int failures = 0;

    logic [31:0] model_rdata [2];
    int          model_last;

    mio_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_rdata (m0_rdata),
        .m0_ready (m0_ready),
        .m0_err   (m0_err),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_rdata (m1_rdata),
        .m1_ready (m1_ready),
        .m1_err   (m1_err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .grant    (grant)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tie rule: master 0 wins, or with round robin the master not granted last.
    function automatic int model_pick(input bit r0, input bit r1);
        if (r0 && r1) begin
`ifdef MIO_ARB_ROUND_ROBIN_EN
            return (model_last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        return r0 ? 0 : 1;
    endfunction

    task automatic model_reset();
        model_rdata[0] = '0;
        model_rdata[1] = '0;
        model_last     = 1;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_grant"},   32'(grant), 32'd0);
        checkOutput({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        checkOutput({tag, "_ready"},   32'({m1_ready, m0_ready}), 32'd0);
        checkOutput({tag, "_err"},     32'({m1_err, m0_err}), 32'd0);
    endtask

    // One full transfer, entered and left at #1 after an edge with the DUT in IDLE.
    // k = BUSY-cycle index carrying mem_ack (>= TIMEOUT means the watchdog fires).
    task automatic applyStimulus(input bit r0, input bit r1, input bit we0, input bit we1,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] d0, input logic [31:0] d1,
                                 input int k, input logic [31:0] rd, input bit hold);
        int          w;
        bit          abort;
        int          last_busy;
        logic [31:0] exp_rd;
        logic [1:0]  onehot;
        w         = model_pick(r0, r1);
        abort     = (k > TIMEOUT - 1);
        last_busy = abort ? TIMEOUT - 1 : k;
        exp_rd    = abort ? 32'd0 : rd;
        onehot    = (w == 1) ? 2'b10 : 2'b01;

        m0_req = r0; m0_we = we0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = we1; m1_addr = a1; m1_wdata = d1;
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom();
        tick();
        model_last = w;
        if (!hold) begin
            m0_req = 1'b0;
            m1_req = 1'b0;
        end
        checkOutput("grant_busy", 32'(grant), 32'(onehot));
        checkOutput("mem_addr",   mem_addr,   (w == 1) ? a1 : a0);
        checkOutput("mem_wdata",  mem_wdata,  (w == 1) ? d1 : d0);
        checkOutput("mem_we",     32'(mem_we), 32'((w == 1) ? we1 : we0));

        for (int j = 0; j <= last_busy; j++) begin
            checkOutput("mem_req_busy", 32'(mem_req), 32'd1);
            checkOutput("ready_busy",   32'({m1_ready, m0_ready}), 32'd0);
            mem_ack   = (j == k);
            mem_rdata = (j == k) ? rd : $urandom();
            tick();
        end

        model_rdata[w] = exp_rd;
        checkOutput("ready_done",   32'({m1_ready, m0_ready}), 32'(onehot));
        checkOutput("err_done",     32'({m1_err, m0_err}), abort ? 32'(onehot) : 32'd0);
        checkOutput("m0_rdata",     m0_rdata, model_rdata[0]);
        checkOutput("m1_rdata",     m1_rdata, model_rdata[1]);
        checkOutput("mem_req_done", 32'(mem_req), 32'd0);
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom();
        tick();
        checkIdleOutputs("idle_after");
        mem_ack = 1'b0;
    endtask

    initial begin
        model_reset();

        #1;
        checkIdleOutputs("reset");
        checkOutput("reset_mem_we",    32'(mem_we), 32'd0);
        checkOutput("reset_mem_addr",  mem_addr,  32'd0);
        checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
        checkOutput("reset_m0_rdata",  m0_rdata,  32'd0);
        checkOutput("reset_m1_rdata",  m1_rdata,  32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Plain read with ack three cycles into the request.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 3, 32'hCAFE0001, 1'b0);
        // Write with no ack: watchdog abort.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h200, 32'h0, 32'h12345678, NO_ACK, 32'h0, 1'b0);
        // Ack lands exactly on watchdog expiry.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 32'h0, 32'h0, TIMEOUT - 1, 32'hA5A50042, 1'b0);
        // Fastest transfer.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h404, 32'h0, 32'h0, 0, 32'h0BADF00D, 1'b0);

        // Reset pulse in the middle of a transfer.
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h500; m1_wdata = 32'h55;
        tick();
        m1_req = 1'b0;
        checkOutput("pre_reset_mem_req", 32'(mem_req), 32'd1);
        tick();
        reset = 1'b0;
        model_reset();
        #1;
        checkIdleOutputs("async_reset");
        checkOutput("async_reset_addr", mem_addr, 32'd0);
        tick();
        reset = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        for (int i = 0; i < TIMEOUT + 2; i++) begin
            tick();
            mem_ack = 1'b0;
            checkIdleOutputs("post_reset");
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h600, 32'h0, 32'h66, 32'h0, 2, 32'h13572468, 1'b0);

        // Fresh reset, then both masters request continuously with ack latency 1.
        reset = 1'b0;
        model_reset();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h1000, 32'h2000, 32'h0, 32'h22, 1, 32'h700 + i, 1'b1);
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();
        checkIdleOutputs("after_stream");

        // Randomized transfers.
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(1, 3);
            applyStimulus(r[0], r[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom(), $urandom(), $urandom(), $urandom(),
                          $urandom_range(0, TIMEOUT + 1), $urandom(), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mio_arbiter.md
MIO_ARBITER -- requirements
Module: mio_arbiter

Interface
REQ-001 Parameter AW, 32, address width of all address ports.
REQ-002 Parameter DW, 32, data width of all data ports.
REQ-003 Parameter TIMEOUT, 255, max cycles waiting for mem_ack before abort; 0 disables watchdog.
REQ-004 Ports below use N in {0,1}: master 0 = CPU, master 1 = secondary (DMA/display).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-007 mN_req  input  1  master N requests a transfer; held until mN_ready.
REQ-008 mN_we  input  1  1 = write, 0 = read; valid with mN_req.
REQ-009 mN_addr  input  AW  transfer address.
REQ-010 mN_wdata  input  DW  write data.
REQ-011 mN_rdata  output  DW  read data, valid in the mN_ready cycle.
REQ-012 mN_ready  output  1  one-cycle pulse: master N transfer complete.
REQ-013 mN_err  output  1  one-cycle pulse with mN_ready: transfer aborted by watchdog.
REQ-014 mem_req  output  1  request to memory/IO, held high until mem_ack or abort.
REQ-015 mem_we  output  1  write strobe qualified by mem_req.
REQ-016 mem_addr  output  AW  registered address to memory.
REQ-017 mem_wdata  output  DW  registered write data.
REQ-018 mem_rdata  input  DW  memory read data, valid with mem_ack.
REQ-019 mem_ack  input  1  memory completion, one cycle.
REQ-020 grant  output  2  one-hot current owner; 2'b00 when idle.

Function
REQ-021 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-022 IDLE: if any mN_req at edge t, latch winner's we/addr/wdata, set grant, go BUSY; mem_req high from cycle t+1.
REQ-023 BUSY: mem_req held with stable mem_addr/mem_we/mem_wdata; on mem_ack capture mem_rdata, go DONE.
REQ-024 DONE: mN_ready of granted master high exactly one cycle, mN_rdata = captured data; mem_req low; next state IDLE.
REQ-025 Latency: mem_ack in cycle t+1+k gives mN_ready in cycle t+2+k; minimum req-to-ready 2 cycles.
REQ-026 mem_ack while not in BUSY is ignored.
REQ-027 mN_req dropped during BUSY does not abort; transfer completes normally.
REQ-028 Watchdog counts BUSY cycles; reaching TIMEOUT without mem_ack: drop mem_req, go DONE, pulse mN_ready and mN_err, mN_rdata = 0.
REQ-029 mem_ack coinciding with watchdog expiry: the ack wins, mN_err stays 0.
REQ-030 A master still requesting after its DONE cycle is re-arbitrated in IDLE like a new request.
REQ-031 Non-granted master outputs mN_ready, mN_err stay 0; mN_rdata holds last value.

Reset
REQ-032 reset low immediately forces IDLE, grant=0, mem_req=0, mem_we=0, all mN_ready/mN_err=0, mem_addr/mem_wdata/mN_rdata=0, watchdog=0, last-grant=master 1.
REQ-033 Reset during BUSY abandons the transfer; no ready pulse is produced after reset release.

Configuration
REQ-034 Macro MIO_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, the master not granted last wins.
REQ-035 MIO_ARB_ROUND_ROBIN_EN undefined: master 0 always wins simultaneous requests; last-grant register not built.

Structure
REQ-036 Package mio_arb_pkg holds the state enum, grant one-hot constants and the abort read value (0).
REQ-037 Watchdog is sub-module mio_arb_watchdog (clear, enable, TIMEOUT compare, expire output).

Verification
REQ-038 m0 read addr 0x100, mem_ack 3 cycles after mem_req, rdata 0xCAFE0001 -> m0_ready pulse one cycle later, m0_rdata=0xCAFE0001, m1_ready=0.
REQ-039 m0 and m1 requesting continuously, ack latency 1 -> grants m0,m1,m0,m1 with RR macro; m0 only without.
REQ-040 m1 write addr 0x200 data 0x12345678, no ack, TIMEOUT=8 -> mem_req drops after 8 BUSY cycles, m1_ready and m1_err pulse, m1_rdata=0.
REQ-041 reset low for 1 cycle mid-BUSY -> mem_req=0, grant=0 immediately; no ready pulse; next request serviced normally.
REQ-042 mem_ack in cycle of watchdog expiry -> m0_ready=1, m0_err=0, rdata captured.
